// File: rtl/seven_stage_memory_arbiter_pkg.sv
// Shared constants and types for the seven-stage core memory arbiter.
package seven_stage_memory_arbiter_pkg;

    // Tag stored per outstanding read: which stage the response belongs to.
    localparam logic TAG_I = 1'b0;
    localparam logic TAG_D = 1'b1;

    // Which requester owns the memory port this cycle.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_I    = 2'd1,
        GRANT_D    = 2'd2
    } grant_e;

endpackage

// File: rtl/seven_stage_tag_fifo.sv
// 1-bit-wide synchronous FIFO holding the requester tag of each outstanding read.
module seven_stage_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     push_tag,
    input  logic                     pop,
    output logic                     head_tag,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] tags;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_tag = tags[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                tags[wr_ptr] <= push_tag;
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/seven_stage_memory_arbiter.sv
// Shares one memory port between the fetch-issue (I) and memory-issue (D)
// stages, routing in-order read responses back via a tag FIFO.
//
// Handshake: a request is presented on mem_read/mem_write with its address
// and data; it is accepted only in a cycle where the port is granted to it
// and mem_ready is high. Read responses arrive on mem_valid strictly in
// request order, one per accepted read; writes are posted with no response.
module seven_stage_memory_arbiter
    import seven_stage_memory_arbiter_pkg::*;
#(
    parameter int CORE            = 0,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_read,
    input  logic [ADDRESS_BITS-1:0]   i_address,
    output logic                      i_valid,
    output logic [DATA_WIDTH-1:0]     i_data,
    input  logic                      d_read,
    input  logic                      d_write,
    input  logic [ADDRESS_BITS-1:0]   d_address,
    input  logic [DATA_WIDTH-1:0]     d_data_in,
    input  logic [DATA_WIDTH/8-1:0]   d_byte_en,
    output logic                      d_valid,
    output logic [DATA_WIDTH-1:0]     d_data_out,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDRESS_BITS-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]     mem_data_out,
    output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
    input  logic                      mem_ready,
    input  logic                      mem_valid,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    output logic                      i_mem_issue_hazard,
    output logic                      d_mem_issue_hazard,
    output logic                      resp_error,
    input  logic                      scan
);

    localparam int CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    grant_e              grant;
    logic                d_req;
    logic                d_is_read;
    logic                i_ok;
    logic                d_ok;
    logic                starve_hit;
    logic                i_accept;
    logic                d_accept;
    logic                push;
    logic                push_tag;
    logic                pop;
    logic                head_tag;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [STARVE_W-1:0] starve_cnt;

    // A combined read+write from D is treated as a write (the write wins).
    assign d_req      = d_read | d_write;
    assign d_is_read  = d_read & ~d_write;
    // Reads need a free tag slot; a same-cycle pop does not free one early.
    assign i_ok       = i_read & ~fifo_full;
    assign d_ok       = d_write | (d_is_read & ~fifo_full);
    assign starve_hit = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Pick the port owner: D by default, I when D cannot go or I is starving.
    always_comb begin
        grant = GRANT_NONE;
        if (i_ok && (starve_hit || !d_ok)) begin
            grant = GRANT_I;
        end else if (d_ok) begin
            grant = GRANT_D;
        end
    end

    assign i_accept = (grant == GRANT_I) & mem_ready;
    assign d_accept = (grant == GRANT_D) & mem_ready;

    assign i_mem_issue_hazard = i_read & ~i_accept;
    assign d_mem_issue_hazard = d_req & ~d_accept;

    // Drive the memory port from the granted requester only.
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = '0;
        mem_data_out = '0;
        mem_byte_en  = '0;
        if (grant == GRANT_I) begin
            mem_read    = 1'b1;
            mem_address = i_address;
        end else if (grant == GRANT_D) begin
            mem_read    = d_is_read;
            mem_write   = d_write;
            mem_address = d_address;
            if (d_write) begin
                mem_data_out = d_data_in;
                mem_byte_en  = d_byte_en;
            end
        end
    end

    assign push     = i_accept | (d_accept & d_is_read);
    assign push_tag = i_accept ? TAG_I : TAG_D;
    assign pop      = mem_valid & ~fifo_empty;

    seven_stage_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .head_tag (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Steer each response to the stage named by the head tag, same cycle.
    always_comb begin
        i_valid    = 1'b0;
        i_data     = '0;
        d_valid    = 1'b0;
        d_data_out = '0;
        if (pop) begin
            if (head_tag == TAG_D) begin
                d_valid    = 1'b1;
                d_data_out = mem_data_in;
            end else begin
                i_valid = 1'b1;
                i_data  = mem_data_in;
            end
        end
    end

    // Count D wins while I waits; any I acceptance or idle I clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (i_accept || !i_read) begin
            starve_cnt <= '0;
        end else if (d_accept && !starve_hit) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    // Flag a response that has no outstanding read to match it; sticky.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_error <= 1'b0;
        end else if (mem_valid && fifo_empty) begin
            resp_error <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    int scan_cycle;

    // Cycle-level trace of arbitration decisions for debug runs.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cycle <= 0;
        end else begin
            scan_cycle <= scan_cycle + 1;
        end
        if (scan && scan_cycle >= SCAN_CYCLES_MIN && scan_cycle <= SCAN_CYCLES_MAX) begin
            $display("core%0d cyc=%0d grant=%s cnt=%0d i_haz=%0b d_haz=%0b",
                     CORE, scan_cycle, grant.name(), fifo_count,
                     i_mem_issue_hazard, d_mem_issue_hazard);
        end
    end
`endif

endmodule

// File: tb/tb_seven_stage_memory_arbiter.sv
// Directed bench for seven_stage_memory_arbiter: inputs change on the falling
// edge and outputs are sampled 1 time unit later, mid-cycle.
module tb_seven_stage_memory_arbiter;

  logic        clock;
  logic        reset;
  logic        i_read;
  logic [31:0] i_address;
  logic        i_valid;
  logic [31:0] i_data;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_data_in;
  logic [3:0]  d_byte_en;
  logic        d_valid;
  logic [31:0] d_data_out;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic [3:0]  mem_byte_en;
  logic        mem_ready;
  logic        mem_valid;
  logic [31:0] mem_data_in;
  logic        i_mem_issue_hazard;
  logic        d_mem_issue_hazard;
  logic        resp_error;
  logic        scan;

  int total;
  int bad;

  seven_stage_memory_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .i_read             (i_read),
    .i_address          (i_address),
    .i_valid            (i_valid),
    .i_data             (i_data),
    .d_read             (d_read),
    .d_write            (d_write),
    .d_address          (d_address),
    .d_data_in          (d_data_in),
    .d_byte_en          (d_byte_en),
    .d_valid            (d_valid),
    .d_data_out         (d_data_out),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_address        (mem_address),
    .mem_data_out       (mem_data_out),
    .mem_byte_en        (mem_byte_en),
    .mem_ready          (mem_ready),
    .mem_valid          (mem_valid),
    .mem_data_in        (mem_data_in),
    .i_mem_issue_hazard (i_mem_issue_hazard),
    .d_mem_issue_hazard (d_mem_issue_hazard),
    .resp_error         (resp_error),
    .scan               (scan)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic idle_inputs();
    i_read      = 1'b0;
    i_address   = '0;
    d_read      = 1'b0;
    d_write     = 1'b0;
    d_address   = '0;
    d_data_in   = '0;
    d_byte_en   = '0;
    mem_valid   = 1'b0;
    mem_data_in = '0;
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_ready = 1'b1;
    reset = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {mem_read, mem_write}); end
    total++; if (mem_address !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_address); end
    total++; if ({i_valid, d_valid, i_mem_issue_hazard, d_mem_issue_hazard, resp_error} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {i_valid, d_valid, i_mem_issue_hazard, d_mem_issue_hazard, resp_error}); end
    total++; if (dut.fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", dut.fifo_count); end
    reset = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    total++; if ({mem_read, mem_write, i_valid, d_valid, resp_error} !== 5'b0) begin bad++; $display("FAIL idle_outputs got=%b exp=00000", {mem_read, mem_write, i_valid, d_valid, resp_error}); end
    total++; if ({mem_data_out, mem_byte_en} !== 36'h0) begin bad++; $display("FAIL idle_wdata got=%h exp=0", {mem_data_out, mem_byte_en}); end
  endtask

  task automatic test_priority();
    // Port not ready: request presented but not accepted, nothing pushed.
    next_cycle();
    i_read = 1'b1; i_address = 32'h0000_0100; mem_ready = 1'b0;
    #1;
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL notready_read got=%b exp=1", mem_read); end
    total++; if (i_mem_issue_hazard !== 1'b1) begin bad++; $display("FAIL notready_ihaz got=%b exp=1", i_mem_issue_hazard); end
    // Both request: D wins.
    next_cycle();
    total++; if (dut.fifo_count !== 3'd0) begin bad++; $display("FAIL notready_count got=%0d exp=0", dut.fifo_count); end
    mem_ready = 1'b1; d_read = 1'b1; d_address = 32'h0000_0200;
    #1;
    total++; if (mem_address !== 32'h0000_0200) begin bad++; $display("FAIL both_addr got=%h exp=00000200", mem_address); end
    total++; if ({mem_read, mem_write} !== 2'b10) begin bad++; $display("FAIL both_strobes got=%b exp=10", {mem_read, mem_write}); end
    total++; if ({i_mem_issue_hazard, d_mem_issue_hazard} !== 2'b10) begin bad++; $display("FAIL both_haz got=%b exp=10", {i_mem_issue_hazard, d_mem_issue_hazard}); end
    // I alone next cycle.
    next_cycle();
    d_read = 1'b0;
    #1;
    total++; if (dut.fifo_count !== 3'd1) begin bad++; $display("FAIL d_push_count got=%0d exp=1", dut.fifo_count); end
    total++; if (mem_address !== 32'h0000_0100) begin bad++; $display("FAIL i_alone_addr got=%h exp=00000100", mem_address); end
    total++; if (i_mem_issue_hazard !== 1'b0) begin bad++; $display("FAIL i_alone_ihaz got=%b exp=0", i_mem_issue_hazard); end
    // First response belongs to D.
    next_cycle();
    i_read = 1'b0; mem_valid = 1'b1; mem_data_in = 32'hAAAA_0000;
    #1;
    total++; if (dut.fifo_count !== 3'd2) begin bad++; $display("FAIL two_out_count got=%0d exp=2", dut.fifo_count); end
    total++; if ({d_valid, i_valid} !== 2'b10) begin bad++; $display("FAIL resp1_valids got=%b exp=10", {d_valid, i_valid}); end
    total++; if (d_data_out !== 32'hAAAA_0000) begin bad++; $display("FAIL resp1_ddata got=%h exp=aaaa0000", d_data_out); end
    total++; if (i_data !== 32'h0) begin bad++; $display("FAIL resp1_idata got=%h exp=0", i_data); end
    // Second response belongs to I.
    next_cycle();
    mem_data_in = 32'h1111_0000;
    #1;
    total++; if ({d_valid, i_valid} !== 2'b01) begin bad++; $display("FAIL resp2_valids got=%b exp=01", {d_valid, i_valid}); end
    total++; if (i_data !== 32'h1111_0000) begin bad++; $display("FAIL resp2_idata got=%h exp=11110000", i_data); end
    total++; if (d_data_out !== 32'h0) begin bad++; $display("FAIL resp2_ddata got=%h exp=0", d_data_out); end
    next_cycle();
    mem_valid = 1'b0; mem_data_in = '0;
    #1;
    total++; if (dut.fifo_count !== 3'd0) begin bad++; $display("FAIL drained_count got=%0d exp=0", dut.fifo_count); end
  endtask

  task automatic test_starve();
    logic exp_i;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      i_read = 1'b1; i_address = 32'h0000_0400;
      d_write = 1'b1; d_address = 32'h0000_0300; d_data_in = 32'hCAFE_0000 + c; d_byte_en = 4'hF;
      #1;
      exp_i = (c == 3);
      total++; if ({mem_read, mem_write} !== {exp_i, ~exp_i}) begin bad++; $display("FAIL starve_strobes c=%0d got=%b exp=%b", c, {mem_read, mem_write}, {exp_i, ~exp_i}); end
      total++; if ({i_mem_issue_hazard, d_mem_issue_hazard} !== {~exp_i, exp_i}) begin bad++; $display("FAIL starve_haz c=%0d got=%b exp=%b", c, {i_mem_issue_hazard, d_mem_issue_hazard}, {~exp_i, exp_i}); end
      total++; if (mem_address !== (exp_i ? 32'h0000_0400 : 32'h0000_0300)) begin bad++; $display("FAIL starve_addr c=%0d got=%h", c, mem_address); end
      if (!exp_i) begin
        total++; if ({mem_data_out, mem_byte_en} !== {32'hCAFE_0000 + c, 4'hF}) begin bad++; $display("FAIL starve_wdata c=%0d got=%h", c, {mem_data_out, mem_byte_en}); end
      end
    end
    // Drain the one I read that went out.
    next_cycle();
    idle_inputs();
    mem_valid = 1'b1; mem_data_in = 32'h2222_0000;
    #1;
    total++; if ({i_valid, d_valid} !== 2'b10) begin bad++; $display("FAIL starve_resp got=%b exp=10", {i_valid, d_valid}); end
    total++; if (i_data !== 32'h2222_0000) begin bad++; $display("FAIL starve_rdata got=%h exp=22220000", i_data); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_full();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      i_read = 1'b1; i_address = 32'h0000_1000 + 32'(k * 4);
      #1;
      total++; if ({mem_read, i_mem_issue_hazard} !== 2'b10) begin bad++; $display("FAIL fill_k%0d got=%b exp=10", k, {mem_read, i_mem_issue_hazard}); end
    end
    // Full: I read blocked.
    next_cycle();
    #1;
    total++; if (dut.fifo_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", dut.fifo_count); end
    total++; if ({mem_read, i_mem_issue_hazard} !== 2'b01) begin bad++; $display("FAIL full_iblock got=%b exp=01", {mem_read, i_mem_issue_hazard}); end
    // Full: write still issued.
    next_cycle();
    d_write = 1'b1; d_address = 32'h0000_2000; d_data_in = 32'h0BAD_F00D; d_byte_en = 4'h3;
    #1;
    total++; if ({mem_write, mem_read, d_mem_issue_hazard, i_mem_issue_hazard} !== 4'b1001) begin bad++; $display("FAIL full_write got=%b exp=1001", {mem_write, mem_read, d_mem_issue_hazard, i_mem_issue_hazard}); end
    total++; if (mem_address !== 32'h0000_2000) begin bad++; $display("FAIL full_waddr got=%h exp=00002000", mem_address); end
    // Full with pop and I read same cycle: pop only.
    next_cycle();
    d_write = 1'b0; d_byte_en = '0; mem_valid = 1'b1; mem_data_in = 32'h5555_0000;
    #1;
    total++; if ({i_valid, i_data} !== {1'b1, 32'h5555_0000}) begin bad++; $display("FAIL full_pop got=%b/%h exp=1/55550000", i_valid, i_data); end
    total++; if ({mem_read, i_mem_issue_hazard} !== 2'b01) begin bad++; $display("FAIL full_pop_block got=%b exp=01", {mem_read, i_mem_issue_hazard}); end
    next_cycle();
    mem_valid = 1'b0; mem_data_in = '0;
    #1;
    total++; if (dut.fifo_count !== 3'd3) begin bad++; $display("FAIL after_pop_count got=%0d exp=3", dut.fifo_count); end
    total++; if ({mem_read, i_mem_issue_hazard} !== 2'b10) begin bad++; $display("FAIL after_pop_accept got=%b exp=10", {mem_read, i_mem_issue_hazard}); end
    next_cycle();
    i_read = 1'b0;
    #1;
    total++; if (dut.fifo_count !== 3'd4) begin bad++; $display("FAIL refill_count got=%0d exp=4", dut.fifo_count); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      i_read = 1'b1; i_address = 32'h0000_3000 + 32'(k * 4);
    end
    next_cycle();
    i_read = 1'b0;
    #1;
    total++; if (dut.fifo_count !== 3'd2) begin bad++; $display("FAIL mid_count got=%0d exp=2", dut.fifo_count); end
    reset = 1'b1;
    next_cycle();
    mem_valid = 1'b1; mem_data_in = 32'h7777_0000;
    #1;
    total++; if (dut.fifo_count !== 3'd0) begin bad++; $display("FAIL mid_reset_count got=%0d exp=0", dut.fifo_count); end
    total++; if ({i_valid, d_valid, resp_error} !== 3'b000) begin bad++; $display("FAIL mid_in_reset got=%b exp=000", {i_valid, d_valid, resp_error}); end
    next_cycle();
    #1;
    total++; if (resp_error !== 1'b0) begin bad++; $display("FAIL mid_reset_err got=%b exp=0", resp_error); end
    reset = 1'b0;
    next_cycle();
    #1;
    total++; if ({resp_error, i_valid, d_valid} !== 3'b100) begin bad++; $display("FAIL orphan_resp got=%b exp=100", {resp_error, i_valid, d_valid}); end
    total++; if ({i_data, d_data_out} !== 64'h0) begin bad++; $display("FAIL orphan_data got=%h exp=0", {i_data, d_data_out}); end
    mem_valid = 1'b0;
    next_cycle();
    #1;
    total++; if (resp_error !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", resp_error); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    scan = 1'b0;
    reset = 1'b1;
    mem_ready = 1'b1;
    idle_inputs();
    test_reset();
    test_priority();
    test_starve();
    test_full();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
